mc_control_fsm: RTL and testbench

//  Multicycle control unit for the ARM-subset datapath: decodes the latched instruction and sequences

---
 rtl/mc_control_fsm_pkg.sv | 83 ++++++++
 rtl/mc_control_fsm_cond_check.sv | 35 +++
 rtl/mc_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle ARM-subset control unit: state encodings,
// ALU/op/condition codes, datapath mux selects and the data-processing ALU decoder.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FPUEX  = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_ORR   = 4'd3;
  localparam logic [3:0] ALU_MUL   = 4'd4;
  localparam logic [3:0] ALU_UMULL = 4'd5;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_FPU = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_ROT8   = 2'b00;
  localparam logic [1:0] IMM_12     = 2'b01;
  localparam logic [1:0] IMM_24     = 2'b10;

  // Multiply pattern only exists in register form; an immediate whose bits [7:4] happen to be 1001 stays a DP op.
  function automatic logic [3:0] aluDecode(input logic [31:0] instr);
    logic [3:0] ctl;
    if (!instr[25] && (instr[7:4] == 4'b1001)) begin
      ctl = instr[23] ? ALU_UMULL : ALU_MUL;
    end else begin
      case (instr[24:21])
        CMD_ADD: ctl = ALU_ADD;
        CMD_SUB: ctl = ALU_SUB;
        CMD_CMP: ctl = ALU_SUB;
        CMD_ORR: ctl = ALU_ORR;
        CMD_AND: ctl = ALU_AND;
        default: ctl = ALU_ADD;
      endcase
    end
    return ctl;
  endfunction

endpackage

// File: rtl/mc_control_fsm_cond_check.sv
// ARM condition-code evaluator: combinational pass/fail of cond[3:0] against the {N,Z,C,V} register.
module mc_control_fsm_cond_check
  import mc_control_fsm_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condEx
);

  logic w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = i_flags;

  always_comb begin
    case (i_cond)
      COND_EQ: o_condEx = w_z;
      COND_NE: o_condEx = ~w_z;
      COND_CS: o_condEx = w_c;
      COND_CC: o_condEx = ~w_c;
      COND_MI: o_condEx = w_n;
      COND_PL: o_condEx = ~w_n;
      COND_VS: o_condEx = w_v;
      COND_VC: o_condEx = ~w_v;
      COND_HI: o_condEx = w_c & ~w_z;
      COND_LS: o_condEx = ~w_c | w_z;
      COND_GE: o_condEx = (w_n == w_v);
      COND_LT: o_condEx = (w_n != w_v);
      COND_GT: o_condEx = ~w_z & (w_n == w_v);
      COND_LE: o_condEx = w_z | (w_n != w_v);
      COND_AL: o_condEx = 1'b1;
      default: o_condEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback, holds NZCV,
// applies condition codes and stalls on memory handshake and fixed-latency FPU.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int unsigned FPU_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        FPUWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic [3:0]  Flags
);

  localparam logic [3:0] LP_FPU_LAST = 4'(FPU_LAT - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_flags;
  logic [3:0] r_fpuCount;

  logic [1:0] w_op;
  logic       w_iBit;
  logic       w_sBit;
  logic       w_condEx;
  logic       w_isCmp;
  logic       w_flagUpdate;
  logic [1:0] w_regSrc;
  logic [1:0] w_immSrc;
  logic [3:0] w_aluCtl;
  logic       w_unused;

  assign w_op     = Instr[27:26];
  assign w_iBit   = Instr[25];
  assign w_sBit   = Instr[20];
  assign w_isCmp  = (w_op == OP_DP) && (Instr[24:21] == CMD_CMP);
  assign w_aluCtl = aluDecode(Instr);
  assign w_regSrc = {(w_op == OP_MEM) && !Instr[20], (w_op == OP_BR)};
  assign w_immSrc = (w_op == OP_MEM) ? IMM_12 : (w_op == OP_BR) ? IMM_24 : IMM_ROT8;
  assign w_unused = ^{Instr[19:8], Instr[3:0]};

  assign w_flagUpdate = (r_state == S_ALUWB) && w_condEx && (w_op != OP_FPU) && (w_sBit || w_isCmp);
  assign Flags        = r_flags;

  mc_control_fsm_cond_check u_condCheck (
    .i_cond   (Instr[31:28]),
    .i_flags  (r_flags),
    .o_condEx (w_condEx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_flags    <= '0;
      r_fpuCount <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_flagUpdate) begin
        r_flags <= ALUFlags;
      end
      if (r_state == S_DECODE) begin
        r_fpuCount <= '0;
      end else if (r_state == S_FPUEX) begin
        r_fpuCount <= r_fpuCount + 4'd1;
      end
    end
  end

  // Outputs depend on reset directly so write strobes drop the instant reset asserts mid-access.
  always_comb begin
    w_nextState = S_FETCH;
    PCWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    FPUWrite    = 1'b0;
    AdrSrc      = 1'b0;
    RegSrc      = 2'b00;
    ALUSrcA     = SRCA_REG;
    ALUSrcB     = SRCB_REG;
    ResultSrc   = RES_ALUOUT;
    ImmSrc      = IMM_ROT8;
    ALUControl  = ALU_ADD;
    if (reset) begin
      if (r_state != S_FETCH) begin
        RegSrc = w_regSrc;
        ImmSrc = w_immSrc;
      end
      case (r_state)
        S_FETCH: begin
          IRWrite     = 1'b1;
          PCWrite     = mem_ready;
          ALUSrcA     = SRCA_PC;
          ALUSrcB     = SRCB_FOUR;
          ResultSrc   = RES_ALU;
          w_nextState = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          if (!w_condEx) begin
            w_nextState = S_FETCH;
          end else begin
            case (w_op)
              OP_DP:   w_nextState = w_iBit ? S_EXECI : S_EXECR;
              OP_MEM:  w_nextState = S_MEMADR;
              OP_BR:   w_nextState = S_BRANCH;
              default: w_nextState = S_FPUEX;
            endcase
          end
        end
        S_EXECR: begin
          ALUSrcB     = SRCB_REG;
          ALUControl  = w_aluCtl;
          w_nextState = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcB     = SRCB_IMM;
          ALUControl  = w_aluCtl;
          w_nextState = S_ALUWB;
        end
        S_ALUWB: begin
          ResultSrc   = RES_ALUOUT;
          RegWrite    = w_condEx && !w_isCmp;
          FPUWrite    = (w_op == OP_FPU);
          w_nextState = S_FETCH;
        end
        S_MEMADR: begin
          ALUSrcB     = SRCB_IMM;
          ALUControl  = Instr[23] ? ALU_ADD : ALU_SUB;
          w_nextState = Instr[20] ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          AdrSrc      = 1'b1;
          w_nextState = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          ResultSrc   = RES_DATA;
          RegWrite    = w_condEx;
          w_nextState = S_FETCH;
        end
        S_MEMWR: begin
          AdrSrc      = 1'b1;
          MemWrite    = w_condEx;
          w_nextState = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_BRANCH: begin
          ALUSrcA     = SRCA_PC;
          ALUSrcB     = SRCB_IMM;
          ResultSrc   = RES_ALU;
          PCWrite     = w_condEx;
          RegWrite    = w_condEx && Instr[24];
          w_nextState = S_FETCH;
        end
        S_FPUEX: begin
          w_nextState = (r_fpuCount == LP_FPU_LAST) ? S_ALUWB : S_FPUEX;
        end
        default: begin
          RegSrc      = 2'b00;
          ImmSrc      = IMM_ROT8;
          w_nextState = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: directed per-cycle vectors push hand-computed
// control words; a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, RegWrite, MemWrite, IRWrite, FPUWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [3:0]  ALUControl, Flags;

  always #5 clk = ~clk;

  mc_control_fsm #(.FPU_LAT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .FPUWrite   (FPUWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags)
  );

  // Control word layout: {PCWrite,RegWrite,MemWrite,IRWrite,FPUWrite,AdrSrc | RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc | ALUControl}
  localparam logic [19:0] ZERO       = 20'h0;
  localparam logic [19:0] FETCH_WAIT = {6'b000100, 10'b00_01_10_10_00, 4'h0};
  localparam logic [19:0] FETCH_GO   = {6'b100100, 10'b00_01_10_10_00, 4'h0};
  localparam logic [19:0] DEC_DP     = {6'b000000, 10'b00_01_10_10_00, 4'h0};
  localparam logic [19:0] DEC_LD     = {6'b000000, 10'b00_01_10_10_01, 4'h0};
  localparam logic [19:0] DEC_ST     = {6'b000000, 10'b10_01_10_10_01, 4'h0};
  localparam logic [19:0] DEC_BR     = {6'b000000, 10'b01_01_10_10_10, 4'h0};
  localparam logic [19:0] EXECI_ADD  = {6'b000000, 10'b00_00_01_00_00, 4'h0};
  localparam logic [19:0] EXECR_SUB  = {6'b000000, 10'b00_00_00_00_00, 4'h1};
  localparam logic [19:0] EXECR_ORR  = {6'b000000, 10'b00_00_00_00_00, 4'h3};
  localparam logic [19:0] EXECR_UMUL = {6'b000000, 10'b00_00_00_00_00, 4'h5};
  localparam logic [19:0] ALUWB_W    = {6'b010000, 10'b00_00_00_00_00, 4'h0};
  localparam logic [19:0] ALUWB_FPU  = {6'b010010, 10'b00_00_00_00_00, 4'h0};
  localparam logic [19:0] MEMADR_LD  = {6'b000000, 10'b00_00_01_00_01, 4'h0};
  localparam logic [19:0] MEMADR_ST  = {6'b000000, 10'b10_00_01_00_01, 4'h1};
  localparam logic [19:0] MEMRD      = {6'b000001, 10'b00_00_00_00_01, 4'h0};
  localparam logic [19:0] MEMWB      = {6'b010000, 10'b00_00_00_01_01, 4'h0};
  localparam logic [19:0] MEMWR      = {6'b001001, 10'b10_00_00_00_01, 4'h0};
  localparam logic [19:0] BRANCH     = {6'b100000, 10'b01_01_01_10_10, 4'h0};
  localparam logic [19:0] BRANCH_L   = {6'b110000, 10'b01_01_01_10_10, 4'h0};

  localparam logic [31:0] I_ADDS  = 32'hE2921001;
  localparam logic [31:0] I_LDR   = 32'hE5921004;
  localparam logic [31:0] I_BEQ   = 32'h0A000002;
  localparam logic [31:0] I_CMP   = 32'hE1500000;
  localparam logic [31:0] I_ADDNE = 32'h10811002;
  localparam logic [31:0] I_BL    = 32'hEB000001;
  localparam logic [31:0] I_ORR   = 32'hE1810002;
  localparam logic [31:0] I_UMULL = 32'hE0810291;
  localparam logic [31:0] I_FPU   = 32'hEC100000;
  localparam logic [31:0] I_STR   = 32'hE5021008;

  typedef struct {
    string       tag;
    logic [19:0] ctl;
    logic [3:0]  flags;
  } expT;

  expT expQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  logic [19:0] actCtl;
  assign actCtl = {PCWrite, RegWrite, MemWrite, IRWrite, FPUWrite, AdrSrc,
                   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  task automatic applyStimulus(input string tag, input logic rst, input logic [31:0] ins,
                               input logic [3:0] af, input logic mr,
                               input logic [19:0] ctl, input logic [3:0] fl);
    expT e;
    @(posedge clk);
    #1;
    reset     = rst;
    Instr     = ins;
    ALUFlags  = af;
    mem_ready = mr;
    e.tag   = tag;
    e.ctl   = ctl;
    e.flags = fl;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e);
    compared++;
    if ((actCtl !== e.ctl) || (Flags !== e.flags)) begin
      mismatched++;
      $display("[TB] FAIL %s: got ctl=%b flags=%b, want ctl=%b flags=%b",
               e.tag, actCtl, Flags, e.ctl, e.flags);
    end
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    reset     = 1'b0;
    Instr     = 32'h0;
    ALUFlags  = 4'h0;
    mem_ready = 1'b0;

    applyStimulus("rst0", 1'b0, 32'h0, 4'h0, 1'b0, ZERO, 4'b0000);
    applyStimulus("rst1", 1'b0, 32'h0, 4'h0, 1'b1, ZERO, 4'b0000);

    applyStimulus("adds_fetch",  1'b1, I_ADDS, 4'b1010, 1'b1, FETCH_GO,  4'b0000);
    applyStimulus("adds_decode", 1'b1, I_ADDS, 4'b1010, 1'b1, DEC_DP,    4'b0000);
    applyStimulus("adds_execi",  1'b1, I_ADDS, 4'b1010, 1'b1, EXECI_ADD, 4'b0000);
    applyStimulus("adds_aluwb",  1'b1, I_ADDS, 4'b1010, 1'b1, ALUWB_W,   4'b0000);

    applyStimulus("ldr_fetch_wait", 1'b1, I_LDR, 4'h0, 1'b0, FETCH_WAIT, 4'b1010);
    applyStimulus("ldr_fetch",      1'b1, I_LDR, 4'h0, 1'b1, FETCH_GO,   4'b1010);
    applyStimulus("ldr_decode",     1'b1, I_LDR, 4'h0, 1'b0, DEC_LD,     4'b1010);
    applyStimulus("ldr_memadr",     1'b1, I_LDR, 4'h0, 1'b0, MEMADR_LD,  4'b1010);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("ldr_memrd_wait%0d", i), 1'b1, I_LDR, 4'h0, 1'b0, MEMRD, 4'b1010);
    end
    applyStimulus("ldr_memrd_done", 1'b1, I_LDR, 4'h0, 1'b1, MEMRD, 4'b1010);
    applyStimulus("ldr_memwb",      1'b1, I_LDR, 4'h0, 1'b0, MEMWB, 4'b1010);

    applyStimulus("beq_nt_fetch",  1'b1, I_BEQ, 4'h0, 1'b1, FETCH_GO, 4'b1010);
    applyStimulus("beq_nt_decode", 1'b1, I_BEQ, 4'h0, 1'b1, DEC_BR,   4'b1010);

    applyStimulus("cmp_fetch",  1'b1, I_CMP, 4'b0100, 1'b1, FETCH_GO,  4'b1010);
    applyStimulus("cmp_decode", 1'b1, I_CMP, 4'b0100, 1'b1, DEC_DP,    4'b1010);
    applyStimulus("cmp_execr",  1'b1, I_CMP, 4'b0100, 1'b1, EXECR_SUB, 4'b1010);
    applyStimulus("cmp_aluwb",  1'b1, I_CMP, 4'b0100, 1'b1, ZERO,      4'b1010);

    applyStimulus("addne_fetch",  1'b1, I_ADDNE, 4'b1111, 1'b1, FETCH_GO, 4'b0100);
    applyStimulus("addne_decode", 1'b1, I_ADDNE, 4'b1111, 1'b1, DEC_DP,   4'b0100);

    applyStimulus("beq_t_fetch",  1'b1, I_BEQ, 4'h0, 1'b1, FETCH_GO, 4'b0100);
    applyStimulus("beq_t_decode", 1'b1, I_BEQ, 4'h0, 1'b1, DEC_BR,   4'b0100);
    applyStimulus("beq_t_branch", 1'b1, I_BEQ, 4'h0, 1'b1, BRANCH,   4'b0100);

    applyStimulus("bl_fetch",  1'b1, I_BL, 4'h0, 1'b1, FETCH_GO, 4'b0100);
    applyStimulus("bl_decode", 1'b1, I_BL, 4'h0, 1'b1, DEC_BR,   4'b0100);
    applyStimulus("bl_branch", 1'b1, I_BL, 4'h0, 1'b1, BRANCH_L, 4'b0100);

    applyStimulus("orr_fetch",  1'b1, I_ORR, 4'b1111, 1'b1, FETCH_GO,  4'b0100);
    applyStimulus("orr_decode", 1'b1, I_ORR, 4'b1111, 1'b1, DEC_DP,    4'b0100);
    applyStimulus("orr_execr",  1'b1, I_ORR, 4'b1111, 1'b1, EXECR_ORR, 4'b0100);
    applyStimulus("orr_aluwb",  1'b1, I_ORR, 4'b1111, 1'b1, ALUWB_W,   4'b0100);

    applyStimulus("umull_fetch",  1'b1, I_UMULL, 4'b1111, 1'b1, FETCH_GO,   4'b0100);
    applyStimulus("umull_decode", 1'b1, I_UMULL, 4'b1111, 1'b1, DEC_DP,     4'b0100);
    applyStimulus("umull_execr",  1'b1, I_UMULL, 4'b1111, 1'b1, EXECR_UMUL, 4'b0100);
    applyStimulus("umull_aluwb",  1'b1, I_UMULL, 4'b1111, 1'b1, ALUWB_W,    4'b0100);

    applyStimulus("fpu_fetch",  1'b1, I_FPU, 4'b1111, 1'b1, FETCH_GO, 4'b0100);
    applyStimulus("fpu_decode", 1'b1, I_FPU, 4'b1111, 1'b1, DEC_DP,   4'b0100);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("fpu_ex%0d", i), 1'b1, I_FPU, 4'b1111, 1'b1, ZERO, 4'b0100);
    end
    applyStimulus("fpu_aluwb", 1'b1, I_FPU, 4'b1111, 1'b1, ALUWB_FPU, 4'b0100);

    applyStimulus("str_fetch",      1'b1, I_STR, 4'h0, 1'b1, FETCH_GO,  4'b0100);
    applyStimulus("str_decode",     1'b1, I_STR, 4'h0, 1'b0, DEC_ST,    4'b0100);
    applyStimulus("str_memadr",     1'b1, I_STR, 4'h0, 1'b0, MEMADR_ST, 4'b0100);
    applyStimulus("str_memwr_wait", 1'b1, I_STR, 4'h0, 1'b0, MEMWR,     4'b0100);
    applyStimulus("str_memwr_done", 1'b1, I_STR, 4'h0, 1'b1, MEMWR,     4'b0100);

    applyStimulus("str2_fetch",  1'b1, I_STR, 4'h0, 1'b1, FETCH_GO,  4'b0100);
    applyStimulus("str2_decode", 1'b1, I_STR, 4'h0, 1'b0, DEC_ST,    4'b0100);
    applyStimulus("str2_memadr", 1'b1, I_STR, 4'h0, 1'b0, MEMADR_ST, 4'b0100);
    applyStimulus("str2_memwr",  1'b1, I_STR, 4'h0, 1'b0, MEMWR,     4'b0100);
    applyStimulus("str2_rst_mid",  1'b0, I_STR, 4'h0, 1'b0, ZERO, 4'b0000);
    applyStimulus("str2_rst_hold", 1'b0, I_STR, 4'h0, 1'b1, ZERO, 4'b0000);
    applyStimulus("post_rst_fetch_wait", 1'b1, I_ADDS, 4'h0, 1'b0, FETCH_WAIT, 4'b0000);
    applyStimulus("post_rst_fetch",      1'b1, I_ADDS, 4'h0, 1'b1, FETCH_GO,   4'b0000);
    applyStimulus("post_rst_decode",     1'b1, I_ADDS, 4'h0, 1'b1, DEC_DP,     4'b0000);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d entries pending, want 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
